// File: rtl/cpu_trace_buffer.sv
// Instruction trace capture for a single-cycle CPU: 16-entry circular FIFO armed by start, halted by opcode 6'h3F.
// Build option: define TRACE_OVERWRITE_EN to overwrite the oldest entry on a full-FIFO capture instead of dropping it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE 00  | waiting for start; the start edge itself captures an entry
// RUN  01  | captures one entry every edge; opCode 6'h3F moves to HALTED
// HALTED 10| no capture, consumer may keep draining; left only via Reset

module cpu_trace_buffer (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [5:0]  opCode,
  input  logic [31:0] curPC,
  input  logic [31:0] Result,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [84:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [4:0]  count,
  output logic        full,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_HALTED = 2'b10;
  localparam logic [5:0] OP_HALT  = 6'b111111;

`ifdef TRACE_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        capture;
  logic        pop;
  logic        do_write;
  logic        do_adv_rd;
  logic        set_ovf;
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [4:0]  count_q;
  logic        ovf_q;
  logic [84:0] entry;
  logic [84:0] mem [16];

  always_ff @(posedge clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (opCode == OP_HALT) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    case (state_q)
      S_IDLE:  capture = start;
      S_RUN:   capture = 1'b1;
      default: capture = 1'b0;
    endcase
    state = state_q;
  end

  assign entry    = {curPC, opCode, rs, rt, rd, Result};
  assign rd_valid = (count_q != 5'd0);
  assign full     = (count_q == 5'd16);
  assign pop      = rd_valid && rd_ready;

  // A full FIFO only accepts a capture if a pop frees a slot or overwrite is built in;
  // in overwrite mode the write lands on the oldest slot, so the read pointer moves too.
  assign do_write  = capture && (!full || pop || OVERWRITE);
  assign do_adv_rd = pop || (capture && full && OVERWRITE);
  assign set_ovf   = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_write)  wr_ptr <= wr_ptr + 4'd1;
      if (do_adv_rd) rd_ptr <= rd_ptr + 4'd1;
      count_q <= count_q + 5'(do_write) - 5'(do_adv_rd);
      if (set_ovf) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset && do_write) mem[wr_ptr] <= entry;
  end

  assign rd_data  = mem[rd_ptr];
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        Reset, start, rd_ready;
  logic [5:0]  opCode;
  logic [31:0] curPC, Result;
  logic [4:0]  rs, rt, rd;
  logic [84:0] rd_data;
  logic        rd_valid, full, overflow;
  logic [4:0]  count;
  logic [1:0]  state;

  int passed = 0;
  int total  = 0;

`ifdef TRACE_OVERWRITE_EN
  localparam bit MOVR = 1'b1;
`else
  localparam bit MOVR = 1'b0;
`endif

  cpu_trace_buffer dut (
    .clk(clk), .Reset(Reset), .start(start), .opCode(opCode), .curPC(curPC),
    .Result(Result), .rs(rs), .rt(rt), .rd(rd), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .full(full),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  logic [84:0] q[$];
  logic [1:0]  mst;
  logic        movf;

  task automatic chk(input string tag, input logic [84:0] obs, input logic [84:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    logic [84:0] e;
    bit p, cap;
    if (!Reset) begin
      q.delete();
      mst  = 2'd0;
      movf = 1'b0;
    end else begin
      p   = (q.size() != 0) && rd_ready;
      cap = (mst == 2'd0 && start) || (mst == 2'd1);
      e   = {curPC, opCode, rs, rt, rd, Result};
      if (p) void'(q.pop_front());
      if (cap) begin
        if (q.size() < 16) q.push_back(e);
        else begin
          movf = 1'b1;
          if (MOVR) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end
      end
      if (mst == 2'd0 && start) mst = 2'd1;
      else if (mst == 2'd1 && opCode == 6'h3F) mst = 2'd2;
    end
  endtask

  task automatic check_all();
    chk("count", 85'(count), 85'(q.size()));
    chk("full", 85'(full), 85'(q.size() == 16));
    chk("rd_valid", 85'(rd_valid), 85'(q.size() != 0));
    chk("overflow", 85'(overflow), 85'(movf));
    chk("state", 85'(state), 85'(mst));
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rnd_fields(input logic [31:0] pc);
    curPC  = pc;
    opCode = 6'($urandom_range(0, 62));
    Result = $urandom;
    rs     = 5'($urandom);
    rt     = 5'($urandom);
    rd     = 5'($urandom);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; rd_ready = 1'b0;
    rnd_fields(32'h0);
    mst = 2'd0; movf = 1'b0;
    @(negedge clk);

    // reset held low while start/rd_ready toggle
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom); rd_ready = 1'($urandom);
      step();
    end
    Reset = 1'b1; start = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("idle_state", 85'(state), 85'(2'b00));

    // three captures ending in halt opcode
    start = 1'b1; rnd_fields(32'd0); step();
    start = 1'b0; rnd_fields(32'd4); step();
    rnd_fields(32'd8); opCode = 6'h3F; step();
    chk("halt_count", 85'(count), 85'd3);
    chk("halt_state", 85'(state), 85'(2'b10));
    chk("halt_head_pc", 85'(rd_data[84:53]), 85'd0);
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); rnd_fields($urandom); step();
    end
    start = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_ready = 1'b0;

    // 20 captures into a 16-deep buffer with no consumer
    Reset = 1'b0; step(); Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 0); rnd_fields(32'(i * 4)); step();
    end
    start = 1'b0;
    chk("ovf_count", 85'(count), 85'd16);
    chk("ovf_full", 85'(full), 85'd1);
    chk("ovf_flag", 85'(overflow), 85'd1);
    chk("ovf_head_pc", 85'(rd_data[84:53]), MOVR ? 85'd16 : 85'd0);

    // exactly full, then capture and pop together for 8 edges
    Reset = 1'b0; step(); Reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      start = (i == 0); rnd_fields(32'(i * 4)); step();
    end
    start = 1'b0;
    chk("fill_count", 85'(count), 85'd16);
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rnd_fields(32'((16 + k) * 4)); step();
      chk("simul_count", 85'(count), 85'd16);
      chk("simul_ovf", 85'(overflow), 85'd0);
      chk("simul_head_pc", 85'(rd_data[84:53]), 85'((k + 1) * 4));
    end
    rd_ready = 1'b0;

    // reset mid-run with 7 entries, then restart
    Reset = 1'b0; step(); Reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      start = (i == 0); rnd_fields(32'(i * 4)); step();
    end
    start = 1'b0;
    chk("mid_count", 85'(count), 85'd7);
    Reset = 1'b0; rnd_fields(32'h200); step();
    chk("rst_count", 85'(count), 85'd0);
    chk("rst_state", 85'(state), 85'(2'b00));
    chk("rst_valid", 85'(rd_valid), 85'd0);
    Reset = 1'b1; start = 1'b1; rnd_fields(32'h1000); step();
    start = 1'b0;
    chk("restart_count", 85'(count), 85'd1);
    chk("restart_head_pc", 85'(rd_data[84:53]), 85'h1000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      Reset    = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 7) == 0);
      rd_ready = 1'($urandom);
      rnd_fields($urandom);
      if ($urandom_range(0, 39) == 0) opCode = 6'h3F;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
